// File: rtl/stall_ctrl_if.sv
// Hazard/stall controller bus: ID-stage operands and control in, ID_EX and
// fetch-side enables out. The slave modport is the controller's view.
interface stall_ctrl_if #(
    parameter int CTRL_W = 7,
    parameter int CNT_W  = 16
);
    logic              IDEX_MemRead_i;
    logic [4:0]        IDEX_RDaddr_i;
    logic [4:0]        RS1addr_i;
    logic [4:0]        RS2addr_i;
    logic [4:0]        RDaddr_i;
    logic [CTRL_W-1:0] ctrl_i;
    logic              flush_i;
    logic              mem_busy_i;
    logic [4:0]        RDaddr_o;
    logic [CTRL_W-1:0] ctrl_o;
    logic              PCWrite_o;
    logic              IFIDWrite_o;
    logic              IFIDFlush_o;
    logic              freeze_o;
    logic              stall_o;
    logic [CNT_W-1:0]  bubble_cnt_o;

    modport master (
        output IDEX_MemRead_i, IDEX_RDaddr_i, RS1addr_i, RS2addr_i, RDaddr_i,
               ctrl_i, flush_i, mem_busy_i,
        input  RDaddr_o, ctrl_o, PCWrite_o, IFIDWrite_o, IFIDFlush_o,
               freeze_o, stall_o, bubble_cnt_o
    );

    modport slave (
        input  IDEX_MemRead_i, IDEX_RDaddr_i, RS1addr_i, RS2addr_i, RDaddr_i,
               ctrl_i, flush_i, mem_busy_i,
        output RDaddr_o, ctrl_o, PCWrite_o, IFIDWrite_o, IFIDFlush_o,
               freeze_o, stall_o, bubble_cnt_o
    );
endinterface

// File: rtl/stall_ctrl.sv
// Load-use hazard/stall controller for the 5-stage RV32I pipeline: bubble
// injection into ID_EX, branch flush gating, memory-wait freeze, bubble counter.
module stall_ctrl #(
    parameter int                CTRL_W     = 7,
    parameter logic [CTRL_W-1:0] BUBBLE_VAL = {CTRL_W{1'b0}},
    parameter int                LOAD_LAT   = 1,
    parameter int                CNT_W      = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    stall_ctrl_if.slave  bus
);

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_t;

    localparam logic [3:0]       REM_INIT  = 4'(LOAD_LAT - 1);
    localparam bit               MULTI_LAT = (LOAD_LAT > 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    state_t            state_r;
    state_t            stateNext_s;
    logic [3:0]        rem_r;
    logic [3:0]        remNext_s;
    logic [CNT_W-1:0]  bubbleCnt_r;
    logic              haz_s;
    logic              bubble_s;
    logic [CTRL_W-1:0] ctrl_s;
    logic [4:0]        rdAddr_s;
    logic              pcWrite_s;
    logic              ifidWrite_s;
    logic              ifidFlush_s;
    logic              freeze_s;
    logic              stall_s;

    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    // Load-use hazard decode and bubble request for this cycle.
    always_comb begin
        haz_s = bus.IDEX_MemRead_i && (bus.IDEX_RDaddr_i != 5'd0) &&
                ((bus.IDEX_RDaddr_i == bus.RS1addr_i) ||
                 (bus.IDEX_RDaddr_i == bus.RS2addr_i));
        if (state_r == STALL) begin
            bubble_s = 1'b1;
        end else begin
            bubble_s = haz_s;
        end
    end

    // Next-state and remaining-bubble logic; a frozen pipeline holds everything.
    always_comb begin
        stateNext_s = state_r;
        remNext_s   = rem_r;
        if (bus.mem_busy_i) begin
            stateNext_s = state_r;
            remNext_s   = rem_r;
        end else begin
            case (state_r)
                RUN: begin
                    if (haz_s && MULTI_LAT) begin
                        stateNext_s = STALL;
                        remNext_s   = REM_INIT;
                    end else begin
                        stateNext_s = RUN;
                    end
                end
                STALL: begin
                    // rem<=1 also covers a corrupted zero so the FSM cannot lock up
                    if (rem_r <= 4'd1) begin
                        stateNext_s = RUN;
                        remNext_s   = 4'd0;
                    end else begin
                        remNext_s   = rem_r - 4'd1;
                    end
                end
                default: begin
                    stateNext_s = RUN;
                    remNext_s   = 4'd0;
                end
            endcase
        end
    end

    // Output decode in priority order: reset, freeze, bubble, flush, normal.
    always_comb begin
        ctrl_s      = BUBBLE_VAL;
        rdAddr_s    = 5'd0;
        pcWrite_s   = 1'b0;
        ifidWrite_s = 1'b0;
        ifidFlush_s = 1'b0;
        freeze_s    = 1'b0;
        stall_s     = 1'b0;
        if (!rst_i) begin
            ctrl_s   = BUBBLE_VAL;
            rdAddr_s = 5'd0;
        end else if (bus.mem_busy_i) begin
            ctrl_s   = bus.ctrl_i;
            rdAddr_s = bus.RDaddr_i;
            freeze_s = 1'b1;
        end else if (bubble_s) begin
            ctrl_s   = BUBBLE_VAL;
            rdAddr_s = 5'd0;
            stall_s  = 1'b1;
        end else begin
            ctrl_s      = bus.ctrl_i;
            rdAddr_s    = bus.RDaddr_i;
            pcWrite_s   = 1'b1;
            ifidWrite_s = 1'b1;
            ifidFlush_s = bus.flush_i;
        end
    end

    // FSM state and remaining-bubble register.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_r <= RUN;
            rem_r   <= 4'd0;
        end else begin
            state_r <= stateNext_s;
            rem_r   <= remNext_s;
        end
    end

    // Saturating count of injected bubble cycles.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            bubbleCnt_r <= {CNT_W{1'b0}};
        end else if (stall_s) begin
            bubbleCnt_r <= satInc(bubbleCnt_r);
        end else begin
            bubbleCnt_r <= bubbleCnt_r;
        end
    end

    assign bus.ctrl_o       = ctrl_s;
    assign bus.RDaddr_o     = rdAddr_s;
    assign bus.PCWrite_o    = pcWrite_s;
    assign bus.IFIDWrite_o  = ifidWrite_s;
    assign bus.IFIDFlush_o  = ifidFlush_s;
    assign bus.freeze_o     = freeze_s;
    assign bus.stall_o      = stall_s;
    assign bus.bubble_cnt_o = bubbleCnt_r;

endmodule
